// File: rtl/sp_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_loader
// Brief    : Boot/preload engine. Packs a valid/ready byte stream
//            little-endian into 32-bit words, writes them through a
//            single-port RAM en/addr/wdata/we/be port and optionally reads
//            every written word back to compare an additive checksum.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_loader #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    input  logic                  byte_last_i,
    output logic                  byte_ready_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic                  ram_bypass_en_o,
    input  logic [31:0]           ram_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] words_o,
    output logic [31:0]           checksum_o,
    output logic                  mismatch_o,
    output logic                  error_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_VREQ  = 3'd3;
    localparam logic [2:0] S_VWAIT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_end_ptr   = ADDR_WIDTH'(RAM_SIZE - 4);
    localparam logic [ADDR_WIDTH-1:0] c_word_step = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_one       = ADDR_WIDTH'(1);

    // Expand a 4-bit byte-enable into a 32-bit data mask.
    function automatic logic [31:0] f_lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_last_ptr;
    logic [ADDR_WIDTH-1:0] r_words;
    logic [1:0]            r_lane;
    logic [3:0]            r_be;
    logic [3:0]            r_final_be;
    logic [31:0]           r_data;
    logic [31:0]           r_checksum;
    logic [31:0]           r_vsum;
    logic                  r_last;
    logic                  r_mismatch;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_vlast;
    logic                  w_in_write;
    logic                  w_in_vreq;
    logic [31:0]           w_wdata_masked;
    logic [31:0]           w_rdata_masked;
    logic [31:0]           w_vsum_next;

    assign w_accept       = (r_state == S_FILL) && byte_valid_i;
    assign w_word_done    = w_accept && ((r_lane == 2'd3) || byte_last_i);
    assign w_vlast        = (r_ptr == r_last_ptr);
    assign w_in_write     = (r_state == S_WRITE);
    assign w_in_vreq      = (r_state == S_VREQ);
    assign w_wdata_masked = r_data & f_lane_mask(r_be);
    // Only the final word can be partial; all earlier words compare in full.
    assign w_rdata_masked = ram_rdata_i & (w_vlast ? f_lane_mask(r_final_be) : 32'hFFFF_FFFF);
    assign w_vsum_next    = r_vsum + w_rdata_masked;

    // State register.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (w_word_done) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_last) begin
                    w_next_state = (VERIFY != 0) ? S_VREQ : S_DONE;
                end else if (r_ptr == c_end_ptr) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_FILL;
                end
            end
            S_VREQ: begin
                w_next_state = S_VWAIT;
            end
            S_VWAIT: begin
                w_next_state = w_vlast ? S_DONE : S_VREQ;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: byte packing, pointer walk, checksums and status flags.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_ptr      <= '0;
            r_base     <= '0;
            r_last_ptr <= '0;
            r_words    <= '0;
            r_lane     <= '0;
            r_be       <= '0;
            r_final_be <= '0;
            r_data     <= '0;
            r_checksum <= '0;
            r_vsum     <= '0;
            r_last     <= 1'b0;
            r_mismatch <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_ptr      <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_base     <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_lane     <= '0;
                        r_be       <= '0;
                        r_data     <= '0;
                        r_words    <= '0;
                        r_checksum <= '0;
                        r_last     <= 1'b0;
                        r_mismatch <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (w_accept) begin
                        r_data[{r_lane, 3'b000} +: 8] <= byte_data_i;
                        r_be[r_lane]                  <= 1'b1;
                        r_lane                        <= r_lane + 2'd1;
                        if (byte_last_i) begin
                            r_last <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_checksum <= r_checksum + w_wdata_masked;
                    r_words    <= r_words + c_one;
                    if (r_last) begin
                        r_final_be <= r_be;
                        r_last_ptr <= r_ptr;
                        r_vsum     <= '0;
                        if (VERIFY != 0) begin
                            r_ptr <= r_base;
                        end
                    end else if (r_ptr == c_end_ptr) begin
                        r_error <= 1'b1;
                    end else begin
                        r_ptr  <= r_ptr + c_word_step;
                        r_lane <= '0;
                        r_be   <= '0;
                    end
                end
                S_VWAIT: begin
                    r_vsum <= w_vsum_next;
                    if (w_vlast) begin
                        r_mismatch <= (w_vsum_next != r_checksum);
                    end else begin
                        r_ptr <= r_ptr + c_word_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode from registers only; bus fields are zero when idle.
    assign byte_ready_o    = (r_state == S_FILL);
    assign ram_en_o        = w_in_write || w_in_vreq;
    assign ram_we_o        = w_in_write;
    assign ram_addr_o      = (w_in_write || w_in_vreq) ? r_ptr : '0;
    assign ram_wdata_o     = w_in_write ? w_wdata_masked : 32'h0;
    assign ram_be_o        = w_in_write ? r_be : (w_in_vreq ? 4'hF : 4'h0);
    assign ram_bypass_en_o = 1'b0;
    assign busy_o          = (r_state != S_IDLE);
    assign done_o          = (r_state == S_DONE);
    assign words_o         = r_words;
    assign checksum_o      = r_checksum;
    assign mismatch_o      = r_mismatch;
    assign error_o         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sp_ram_loader
// Brief    : Scoreboard bench for sp_ram_loader with a word RAM model,
//            directed loads and randomized loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_loader;

    localparam int RAM_SIZE = 512;
    localparam int AW       = 9;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = '0;
    logic          byte_last_i = 1'b0;
    logic          byte_ready_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic          ram_bypass_en_o;
    bit   [31:0]   ram_rdata_i;
    logic          busy_o;
    logic          done_o;
    logic [AW-1:0] words_o;
    logic [31:0]   checksum_o;
    logic          mismatch_o;
    logic          error_o;

    always #5 clk = ~clk;

    sp_ram_loader #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .VERIFY(1)) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_last_i(byte_last_i),
        .byte_ready_o(byte_ready_o), .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_bypass_en_o(ram_bypass_en_o), .ram_rdata_i(ram_rdata_i), .busy_o(busy_o),
        .done_o(done_o), .words_o(words_o), .checksum_o(checksum_o),
        .mismatch_o(mismatch_o), .error_o(error_o)
    );

    // RAM model: byte-enabled writes, one-cycle read latency, optional bit-0 fault.
    bit [31:0]     mem [RAM_SIZE/4];
    bit            flip_en = 1'b0;
    logic [AW-1:0] flip_addr = '0;
    always @(posedge clk) begin
        if (ram_en_o && ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
        if (ram_en_o && !ram_we_o)
            ram_rdata_i <= mem[ram_addr_o[AW-1:2]] ^ ((flip_en && ram_addr_o == flip_addr) ? 32'h1 : 32'h0);
    end

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
    typedef struct packed { logic [AW-1:0] words; logic [31:0] csum; logic mism; logic err; } res_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    res_t          exp_res[$];
    logic [7:0]    stim[$];
    int            total = 0;
    int            bad = 0;
    int            done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_status"}, {byte_ready_o, busy_o, done_o, words_o, checksum_o, mismatch_o, error_o}, 64'h0);
        check({name, "_ram"}, {ram_en_o, ram_we_o, ram_bypass_en_o, ram_be_o, ram_addr_o, ram_wdata_o}, 64'h0);
    endtask

    // Reference model: chunk the byte list into little-endian words.
    task automatic model_load(input logic [AW-1:0] base, input bit has_last, input int flip_word,
                              output logic [AW-1:0] fa, output int n_acc);
        int         ptr = int'(base) & ~3;
        int         i = 0;
        int         nb = stim.size();
        logic [31:0] csum = 0;
        logic [31:0] vsum = 0;
        bit         err = 0;
        wr_t        w;
        wr_t        list[$];
        res_t       r;
        while (i < nb) begin
            w.addr = AW'(ptr);
            w.data = 0;
            w.be   = 0;
            for (int k = 0; k < 4 && i < nb; k++) begin
                w.data[8*k +: 8] = stim[i];
                w.be[k] = 1'b1;
                i++;
            end
            exp_wr.push_back(w);
            list.push_back(w);
            csum += w.data;
            if (has_last && i == nb) break;
            if (ptr == RAM_SIZE - 4) begin
                err = 1;
                break;
            end
            ptr += 4;
        end
        fa = (flip_word >= 0 && flip_word < list.size()) ? list[flip_word].addr : '1;
        if (!err) begin
            foreach (list[j]) begin
                exp_rd.push_back(list[j].addr);
                vsum += list[j].data ^ ((j == flip_word) ? 32'h1 : 32'h0);
            end
        end
        r.words = AW'(list.size());
        r.csum  = csum;
        r.mism  = !err && (vsum != csum);
        r.err   = err;
        exp_res.push_back(r);
        n_acc = i;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a RAM access or done.
    task automatic monitor_loop();
        bit            done_prev = 0;
        wr_t           w;
        res_t          r;
        logic [AW-1:0] ra;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                done_prev = 0;
                continue;
            end
            if (done_prev) check("done_single_pulse", {done_o, busy_o}, 0);
            done_prev = done_o;
            if (ram_en_o && ram_we_o) begin
                if (exp_wr.size() == 0) check("unexpected_write", {ram_addr_o, ram_wdata_o}, 0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", ram_addr_o, w.addr);
                    check("wr_data", ram_wdata_o, w.data);
                    check("wr_be", ram_be_o, w.be);
                end
            end
            if (ram_en_o && !ram_we_o) begin
                if (exp_rd.size() == 0) check("unexpected_read", {1'b1, ram_addr_o}, 0);
                else begin
                    ra = exp_rd.pop_front();
                    check("rd_addr", {ram_be_o, ram_addr_o}, {4'hF, ra});
                end
            end
            if (done_o) begin
                done_seen++;
                if (exp_res.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    r = exp_res.pop_front();
                    check("words", words_o, r.words);
                    check("checksum", checksum_o, r.csum);
                    check("mismatch", mismatch_o, r.mism);
                    check("error", error_o, r.err);
                end
            end
        end
    endtask

    task automatic run_load(input logic [AW-1:0] base, input bit has_last, input bit gap,
                            input bit poke, input int flip_word);
        logic [AW-1:0] fa;
        int d0 = done_seen;
        int idx = 0;
        int cyc = 0;
        int exp_acc;
        bit tog = 1;
        model_load(base, has_last, flip_word, fa, exp_acc);
        flip_en   = (flip_word >= 0);
        flip_addr = fa;
        @(negedge clk);
        start_i = 1'b1;
        base_addr_i = base;
        @(negedge clk);
        start_i = 1'b0;
        while (idx < stim.size() && cyc < 500) begin
            if (!busy_o) break;
            start_i      = poke && (idx == 2);
            base_addr_i  = poke ? (base ^ 9'h040) : base;
            byte_valid_i = gap ? tog : 1'b1;
            tog          = !tog;
            byte_data_i  = stim[idx];
            byte_last_i  = has_last && (idx == stim.size() - 1);
            if (byte_valid_i && byte_ready_o) idx++;
            @(negedge clk);
            cyc++;
        end
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        start_i      = 1'b0;
        cyc = 0;
        while (done_seen == d0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("bytes_accepted", idx, exp_acc);
        check("done_count", done_seen - d0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic seq_stim(input int first, input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'(first + i));
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Aligned load
        seq_stim(1, 8);
        run_load(9'h100, 1, 0, 0, -1);
        // Partial last word
        stim = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load(9'h000, 1, 0, 0, -1);
        // Readback fault on word 1
        seq_stim(1, 8);
        run_load(9'h100, 1, 0, 0, 1);
        // Overflow at the top of RAM, no last
        seq_stim(8'hA0, 12);
        run_load(9'h1F8, 0, 0, 0, -1);
        check("ready_after_overflow", {byte_ready_o, busy_o}, 0);
        // Gapped valid with a start pulse during FILL
        seq_stim(1, 8);
        run_load(9'h100, 1, 1, 1, -1);

        // Reset after two accepted bytes
        @(negedge clk);
        start_i = 1'b1;
        base_addr_i = 9'h040;
        @(negedge clk);
        start_i = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i = 8'hA1;
        @(negedge clk);
        byte_data_i = 8'hA2;
        @(negedge clk);
        byte_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1 check_all_zero("reset_midop");
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        stim = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        run_load(9'h020, 1, 0, 0, -1);

        // Randomized loads
        for (int t = 0; t < 12; t++) begin
            int nb = $urandom_range(1, 24);
            int nw = (nb + 3) / 4;
            int wd = $urandom_range(0, RAM_SIZE / 4 - nw);
            int fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
            stim.delete();
            for (int i = 0; i < nb; i++) stim.push_back(8'($urandom));
            run_load(AW'(wd * 4 + int'($urandom_range(0, 3))), 1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), fw);
        end

        repeat (4) @(negedge clk);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_reads", exp_rd.size(), 0);
        check("leftover_results", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_loader.md
Name: sp_ram_loader

Overview:
- Initiator for the single-port RAM wrapper interface: accepts a byte stream (valid/ready), packs bytes little-endian into 32-bit words and writes them to RAM through the en/addr/wdata/we/be port.
- After the last byte, optionally reads every written word back and compares an additive checksum against the one computed on the write side.
- Used as the boot/preload engine in front of the instruction or data RAM, for example behind a UART or SPI byte source.

Parameters:
- RAM_SIZE, 32768, RAM size in bytes; must match the target RAM.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width of the RAM port.
- VERIFY, 1, 1 = run the readback/checksum pass after loading; 0 = go straight to DONE.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle start pulse; ignored unless IDLE.
- base_addr_i  in  ADDR_WIDTH  byte start address, sampled on start; bits [1:0] forced to 0.
- byte_valid_i  in  1  source byte valid.
- byte_data_i  in  8  source byte.
- byte_last_i  in  1  qualifies the final byte of the transfer.
- byte_ready_o  out  1  loader ready; a byte is accepted when valid & ready.
- ram_en_o  out  1  RAM request strobe.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address, word aligned.
- ram_wdata_o  out  32  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_bypass_en_o  out  1  constant 0.
- ram_rdata_i  in  32  RAM read data, valid one cycle after a read request.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at the end of a transfer.
- words_o  out  ADDR_WIDTH  number of words written.
- checksum_o  out  32  write-side checksum.
- mismatch_o  out  1  verify checksum differed from the write-side checksum.
- error_o  out  1  RAM end reached before byte_last_i.

Behaviour:
- Reset (asynchronous): state IDLE. All outputs are 0, including the status outputs. The write pointer, lane counter and byte-enable accumulator are cleared. Reset mid-operation aborts any RAM access immediately; no further write is issued.
- Output timing: RAM and status outputs are decoded from registers only. There is no combinational path from any input to any output.
- IDLE: byte_ready_o=0. On start_i: set ptr=base&~3, clear lane/be/words/checksum, clear mismatch_o and error_o, go to FILL. Status outputs otherwise hold their values until the next start.
- FILL: byte_ready_o=1.
  - On accept: data[8*lane+:8]=byte, be[lane]=1, lane++.
  - If lane was 3, or byte_last_i=1, go to WRITE; byte_ready_o is 0 in the next cycle.
- WRITE (exactly 1 cycle): ram_en_o=1, ram_we_o=1, ram_addr_o=ptr, ram_wdata_o=data, ram_be_o=be.
  - Unenabled lanes of ram_wdata_o are 0.
  - checksum += data with unenabled lanes zeroed (mod 2^32).
  - words_o++.
  - Next state:
    - If last was seen: save the final be, go to VREQ with ptr=base if VERIFY=1, else go to DONE.
    - Else if ptr==RAM_SIZE-4: error_o=1, go to DONE.
    - Else: ptr+=4, clear lane/be, go to FILL.
- Throughput: 5 cycles per full word with continuous input; a gapped byte_valid_i only stretches FILL.
- VREQ (1 cycle): ram_en_o=1, ram_we_o=0, ram_be_o=4'hF, ram_addr_o=ptr.
- VWAIT (1 cycle): capture ram_rdata_i.
  - Mask with the saved final be on the last word, full mask otherwise.
  - Add into the verify sum.
  - If this was the last word: mismatch_o = (sum != checksum_o), go to DONE. Else ptr+=4, go to VREQ.
  - Verify cost: 2 cycles per word.
- DONE: done_o=1 for one cycle, then IDLE; busy_o falls with that transition.
- Edge rules:
  - Outside WRITE/VREQ, ram_en_o=0 and ram_we_o=0.
  - start_i while busy is ignored.
  - byte_last_i is only sampled on an accepted byte.
  - An empty transfer cannot occur, because last always accompanies a byte.

Test Plan:
- Aligned load: base 0x100, bytes 0x01..0x08 with last on the 8th -> writes (0x100, 0x04030201, be F) and (0x104, 0x08070605, be F); words_o=2, checksum_o=0x0C0A0806, mismatch_o=0, one done_o pulse.
- Partial word: base 0x0, bytes 11 22 33 44 55 with last on 55 -> second write addr 0x4, wdata 0x00000055, be 0x1; checksum_o=0x44332266; verify reads 2 words; mismatch_o=0.
- Readback fault: as the aligned load, but the RAM model flips bit 0 of word 1 on read -> mismatch_o=1, error_o=0, done_o pulses.
- Overflow: RAM_SIZE=64, base 0x38, more than 8 bytes offered without last -> writes at 0x38 and 0x3C only; error_o=1; byte_ready_o stays 0 after the 8th byte; no verify pass.
- Backpressure/ignore: byte_valid_i toggling every other cycle gives the same writes as the aligned load; start_i pulsed during FILL has no effect on ptr or counters.
- Reset mid-op: assert rst_i after 2 bytes accepted -> all outputs 0 in the same cycle, no RAM write; a subsequent start_i with base 0x20 loads correctly from 0x20.
